// File: rtl/sni_match_scheduler_if.sv
// Byte stream in, engine word/reset out, and per-string result handshake for the SNI match scheduler.
interface sni_match_scheduler_if;
  logic        i_sni_valid;
  logic [7:0]  i_sni_data;
  logic        i_sni_last;
  logic        o_sni_ready;
  logic        o_eng_rst;
  logic        o_eng_valid;
  logic [15:0] o_eng_data;
  logic        i_eng_matched;
  logic        o_res_valid;
  logic        o_res_matched;
  logic        o_res_trunc;
  logic [15:0] o_res_len;
  logic        i_res_ready;
  logic        o_busy;

  modport slave (
    input  i_sni_valid, i_sni_data, i_sni_last, i_eng_matched, i_res_ready,
    output o_sni_ready, o_eng_rst, o_eng_valid, o_eng_data,
    output o_res_valid, o_res_matched, o_res_trunc, o_res_len, o_busy
  );

  modport master (
    output i_sni_valid, i_sni_data, i_sni_last, i_eng_matched, i_res_ready,
    input  o_sni_ready, o_eng_rst, o_eng_valid, o_eng_data,
    input  o_res_valid, o_res_matched, o_res_trunc, o_res_len, o_busy
  );
endinterface

// File: rtl/sni_match_scheduler.sv
// Packs SNI bytes into 16-bit words for a shared match engine, resets the engine between strings,
// and returns one sticky match verdict per string once the engine pipeline has drained.
module sni_match_scheduler #(
  parameter int unsigned CLR_CYCLES = 4,
  parameter int unsigned MATCH_LAT  = 3,
  parameter int unsigned MAX_LEN    = 255,
  parameter logic [7:0]  PAD_BYTE   = 8'h00
) (
  input logic                  i_clk,
  input logic                  i_rst,
  sni_match_scheduler_if.slave bus
);
  localparam int CW      = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam int DW      = (MATCH_LAT > 1) ? $clog2(MATCH_LAT) : 1;
  localparam int FW      = $clog2(MAX_LEN + 1);
  localparam bit MAX_ODD = (MAX_LEN % 2) == 1;

  typedef enum logic [1:0] {CLEAR, FEED, DRAIN, REPORT} state_e;

  state_e        state_q;
  logic [CW-1:0] clr_cnt_q;
  logic [DW-1:0] drn_cnt_q;
  logic [FW-1:0] fwd_q;
  logic [7:0]    hi_q;
  logic [15:0]   len_q;
  logic          trunc_q;
  logic          match_q;

  logic          eng_rst_q;
  logic          sni_ready_q;
  logic          eng_valid_q;
  logic [15:0]   eng_data_q;
  logic          res_valid_q;
  logic          res_matched_q;
  logic          res_trunc_q;
  logic [15:0]   res_len_q;
  logic          busy_q;

  logic          accept;
  logic          fwd_ok;
  logic          match_d;
  logic [15:0]   len_d;

  assign accept  = sni_ready_q && bus.i_sni_valid;
  assign fwd_ok  = fwd_q < FW'(MAX_LEN);
  assign match_d = match_q | bus.i_eng_matched;
  assign len_d   = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= CLEAR;
      clr_cnt_q     <= '0;
      drn_cnt_q     <= '0;
      fwd_q         <= '0;
      hi_q          <= '0;
      len_q         <= '0;
      trunc_q       <= 1'b0;
      match_q       <= 1'b0;
      eng_rst_q     <= 1'b1;
      sni_ready_q   <= 1'b0;
      eng_valid_q   <= 1'b0;
      eng_data_q    <= '0;
      res_valid_q   <= 1'b0;
      res_matched_q <= 1'b0;
      res_trunc_q   <= 1'b0;
      res_len_q     <= '0;
      busy_q        <= 1'b0;
    end else begin
      eng_valid_q <= 1'b0;
      case (state_q)
        CLEAR: begin
          if (clr_cnt_q == CW'(CLR_CYCLES - 1)) begin
            state_q     <= FEED;
            clr_cnt_q   <= '0;
            eng_rst_q   <= 1'b0;
            sni_ready_q <= 1'b1;
            busy_q      <= 1'b1;
            fwd_q       <= '0;
            hi_q        <= '0;
            len_q       <= '0;
            trunc_q     <= 1'b0;
            match_q     <= 1'b0;
          end else begin
            clr_cnt_q <= clr_cnt_q + CW'(1);
          end
        end
        FEED: begin
          match_q <= match_d;
          if (accept) begin
            len_q <= len_d;
            if (fwd_ok) begin
              fwd_q <= fwd_q + FW'(1);
              if (fwd_q[0]) begin
                eng_valid_q <= 1'b1;
                eng_data_q  <= {hi_q, bus.i_sni_data};
              end else if (bus.i_sni_last) begin
                eng_valid_q <= 1'b1;
                eng_data_q  <= {bus.i_sni_data, PAD_BYTE};
              end else begin
                hi_q <= bus.i_sni_data;
              end
            end else begin
              trunc_q <= 1'b1;
              // An odd MAX_LEN leaves a half word pending; flush it on the first dropped byte.
              if (MAX_ODD && !trunc_q) begin
                eng_valid_q <= 1'b1;
                eng_data_q  <= {hi_q, PAD_BYTE};
              end
            end
            if (bus.i_sni_last) begin
              state_q     <= DRAIN;
              sni_ready_q <= 1'b0;
              drn_cnt_q   <= '0;
            end
          end
        end
        DRAIN: begin
          match_q <= match_d;
          // The cycle carrying the final engine beat is not part of the drain window.
          if (!eng_valid_q) begin
            if (drn_cnt_q == DW'(MATCH_LAT - 1)) begin
              state_q       <= REPORT;
              res_valid_q   <= 1'b1;
              res_matched_q <= match_d;
              res_trunc_q   <= trunc_q;
              res_len_q     <= len_q;
            end else begin
              drn_cnt_q <= drn_cnt_q + DW'(1);
            end
          end
        end
        REPORT: begin
          if (bus.i_res_ready) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= '0;
            res_valid_q <= 1'b0;
            eng_rst_q   <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  assign bus.o_sni_ready   = sni_ready_q;
  assign bus.o_eng_rst     = eng_rst_q;
  assign bus.o_eng_valid   = eng_valid_q;
  assign bus.o_eng_data    = eng_data_q;
  assign bus.o_res_valid   = res_valid_q;
  assign bus.o_res_matched = res_matched_q;
  assign bus.o_res_trunc   = res_trunc_q;
  assign bus.o_res_len     = res_len_q;
  assign bus.o_busy        = busy_q;
endmodule

// File: tb/tb_sni_match_scheduler.sv
// Directed and random SNI strings checked against a string-level model; the engine stand-in
// flags word 16'h6364 MATCH_LAT cycles after it is presented.
module tb_sni_match_scheduler;
  localparam int          CLR_CYCLES = 4;
  localparam int          MATCH_LAT  = 3;
  localparam int          MAX_LEN    = 255;
  localparam logic [7:0]  PAD_BYTE   = 8'h00;
  localparam logic [15:0] PAT        = 16'h6364;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sni_match_scheduler_if bus();

  sni_match_scheduler #(
    .CLR_CYCLES(CLR_CYCLES),
    .MATCH_LAT (MATCH_LAT),
    .MAX_LEN   (MAX_LEN),
    .PAD_BYTE  (PAD_BYTE)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  logic                 hit_s   = 1'b0;
  logic                 erst_s  = 1'b1;
  logic                 force_m = 1'b0;
  logic [MATCH_LAT-1:0] pipe    = '0;

  always @(negedge clk) begin
    hit_s  = (bus.o_eng_valid === 1'b1) && (bus.o_eng_data === PAT);
    erst_s = bus.o_eng_rst;
  end

  always @(posedge clk) begin
    if (erst_s) pipe <= '0;
    else        pipe <= {pipe[MATCH_LAT-2:0], hit_s};
  end

  assign bus.i_eng_matched = pipe[MATCH_LAT-1] | force_m;

  logic [15:0] beats[$];
  always @(negedge clk) if (bus.o_eng_valid === 1'b1) beats.push_back(bus.o_eng_data);

  int checks = 0;
  int errors = 0;
  int sid    = 0;
  logic [7:0] cur_str[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (string %0d): observed %0h expected %0h", tag, sid, obs, exp);
    end
  endtask

  task automatic set_text(input string t);
    cur_str.delete();
    for (int k = 0; k < t.len(); k++) cur_str.push_back(t[k]);
  endtask

  task automatic set_seq(input int n);
    cur_str.delete();
    for (int k = 0; k < n; k++) cur_str.push_back(8'h61 + 8'(k % 26));
  endtask

  task automatic wait_clear(input bit force_clr);
    int n;
    n = 0;
    while (bus.o_eng_rst === 1'b1 && n < 50) begin
      check("clear_ready_low", bus.o_sni_ready, 0);
      force_m = force_clr && (n == CLR_CYCLES - 1);
      @(negedge clk);
      n++;
    end
    force_m = 1'b0;
    check("clear_cycles", n, CLR_CYCLES);
    check("feed_ready_busy", {bus.o_sni_ready, bus.o_busy}, 2'b11);
  endtask

  task automatic run_string(input bit gaps, input int hold, input bit hold_hi,
                            input int force_off, input bit force_clr);
    logic [15:0] exp_w[$];
    logic [15:0] exp_len;
    logic [15:0] w;
    int          n, fwd, base, i, exp_lat;
    bit          exp_trunc, exp_match, late_beat, dropped;
    sid++;
    n   = cur_str.size();
    fwd = (n < MAX_LEN) ? n : MAX_LEN;
    for (int k = 0; k < fwd; k += 2) begin
      w = {cur_str[k], (k + 1 < fwd) ? cur_str[k+1] : PAD_BYTE};
      exp_w.push_back(w);
    end
    exp_trunc = n > MAX_LEN;
    exp_len   = (n > 65535) ? 16'hFFFF : 16'(n);
    exp_match = 1'b0;
    foreach (exp_w[k]) if (exp_w[k] == PAT) exp_match = 1'b1;
    late_beat = (n <= MAX_LEN) || ((MAX_LEN % 2 == 1) && (n == MAX_LEN + 1));
    exp_lat   = late_beat ? MATCH_LAT + 2 : MATCH_LAT + 1;
    if (force_off > 0 && force_off < exp_lat) exp_match = 1'b1;

    bus.i_res_ready = hold_hi;
    wait_clear(force_clr);
    base    = beats.size();
    dropped = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        bus.i_sni_valid = 1'b0;
        bus.i_sni_last  = 1'b0;
        @(negedge clk);
        if (bus.o_sni_ready !== 1'b1) dropped = 1'b1;
      end
      if (bus.o_sni_ready !== 1'b1) dropped = 1'b1;
      bus.i_sni_valid = 1'b1;
      bus.i_sni_data  = cur_str[k];
      bus.i_sni_last  = (k == n - 1);
      @(negedge clk);
    end
    bus.i_sni_valid = 1'b0;
    bus.i_sni_last  = 1'b0;
    check("ready_through_feed", dropped, 0);
    check("ready_drops_after_last", bus.o_sni_ready, 0);
    check("final_beat_next_cycle", bus.o_eng_valid, late_beat);

    i = 1;
    while (bus.o_res_valid !== 1'b1 && i < 40) begin
      force_m = (i == force_off);
      @(negedge clk);
      i++;
    end
    force_m = 1'b0;
    check("result_latency", i, exp_lat);
    check("res_valid", bus.o_res_valid, 1);
    check("beat_count", beats.size() - base, exp_w.size());
    for (int k = 0; k < exp_w.size() && base + k < beats.size(); k++)
      check("beat_data", beats[base+k], exp_w[k]);
    check("res_matched", bus.o_res_matched, exp_match);
    check("res_trunc", bus.o_res_trunc, exp_trunc);
    check("res_len", bus.o_res_len, exp_len);
    check("busy_report", bus.o_busy, 1);

    if (!hold_hi) begin
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        check("hold_stable",
              {bus.o_res_valid, bus.o_res_matched, bus.o_res_trunc, bus.o_res_len,
               bus.o_sni_ready, bus.o_eng_valid},
              {1'b1, exp_match, exp_trunc, exp_len, 2'b00});
      end
      bus.i_res_ready = 1'b1;
    end
    @(negedge clk);
    bus.i_res_ready = 1'b0;
    check("handshake_to_clear", {bus.o_res_valid, bus.o_eng_rst, bus.o_busy}, 3'b010);
  endtask

  task automatic abort_test();
    sid++;
    wait_clear(1'b0);
    for (int k = 0; k < 3; k++) begin
      bus.i_sni_valid = 1'b1;
      bus.i_sni_data  = 8'h41 + 8'(k);
      bus.i_sni_last  = 1'b0;
      @(negedge clk);
    end
    bus.i_sni_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("abort_state",
          {bus.o_eng_rst, bus.o_sni_ready, bus.o_eng_valid, bus.o_res_valid, bus.o_busy},
          5'b10000);
    rst = 1'b0;
  endtask

  initial begin
    bus.i_sni_valid = 1'b0;
    bus.i_sni_data  = 8'h00;
    bus.i_sni_last  = 1'b0;
    bus.i_res_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_ctrl",
          {bus.o_eng_rst, bus.o_sni_ready, bus.o_eng_valid, bus.o_res_valid,
           bus.o_res_matched, bus.o_res_trunc, bus.o_busy}, 7'b1000000);
    check("reset_data", {bus.o_eng_data, bus.o_res_len}, 32'h0);
    rst = 1'b0;

    set_text("ab");  run_string(1'b0, 0, 1'b0, 0, 1'b0);
    set_text("cd");  run_string(1'b0, 0, 1'b0, 0, 1'b0);
    set_text("xyz"); run_string(1'b0, 0, 1'b0, 0, 1'b0);
    set_seq(300);    run_string(1'b0, 0, 1'b0, 0, 1'b0);
    set_text("qq");  run_string(1'b0, 0, 1'b0, MATCH_LAT + 1, 1'b0);
    set_text("qq");  run_string(1'b0, 0, 1'b0, 0, 1'b1);
    set_text("cd");  run_string(1'b0, 10, 1'b0, 0, 1'b0);
    set_text("ab");  run_string(1'b1, 0, 1'b1, 0, 1'b0);
    abort_test();
    set_text("ab");  run_string(1'b0, 0, 1'b0, 0, 1'b0);
    set_seq(255);    run_string(1'b1, 1, 1'b0, 0, 1'b0);
    set_seq(256);    run_string(1'b0, 0, 1'b0, 0, 1'b0);
    set_seq(257);    run_string(1'b1, 2, 1'b0, 0, 1'b0);

    for (int r = 0; r < 24; r++) begin
      cur_str.delete();
      repeat ($urandom_range(1, 12)) cur_str.push_back(8'h61 + 8'($urandom_range(0, 3)));
      run_string(1'($urandom_range(0, 1)), $urandom_range(0, 3),
                 ($urandom_range(0, 2) == 0), 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sni_match_scheduler.md
Name: sni_match_scheduler

Overview:
Sequences one shared 2-byte-per-cycle SNI pattern-match engine over a stream of SNI strings. It accepts SNI bytes one at a time, packs them into 16-bit words (first byte in [15:8]), and drives the engine's valid and data inputs. Between strings it holds the engine in reset so every string starts from a clean state. It waits out the engine pipeline, then returns one sticky match verdict per string over a valid/ready result handshake.

Parameters:
CLR_CYCLES, 4, cycles o_eng_rst is held high before each string; must be >= MATCH_LAT+1.
MATCH_LAT, 3, cycles from o_eng_valid to the corresponding i_eng_matched (engine pipeline depth).
MAX_LEN, 255, maximum SNI bytes forwarded to the engine per string.
PAD_BYTE, 8'h00, filler for the low byte of the final word of an odd-length string.

Ports:
i_clk  in  1  clock
i_rst  in  1  reset; synchronous, active-high; clock i_clk
i_sni_valid  in  1  input byte valid
i_sni_data  in  8  SNI byte
i_sni_last  in  1  marks the final byte of the string
o_sni_ready  out  1  scheduler accepts a byte this cycle
o_eng_rst  out  1  engine synchronous reset
o_eng_valid  out  1  engine word valid
o_eng_data  out  16  engine word; [15:8] is the earlier byte
i_eng_matched  in  1  engine match output
o_res_valid  out  1  result valid
o_res_matched  out  1  1 = the string matched
o_res_trunc  out  1  1 = string exceeded MAX_LEN
o_res_len  out  16  bytes received, saturating at 16'hFFFF
i_res_ready  in  1  result consumer ready
o_busy  out  1  high in every state except CLEAR

Behaviour:
- All outputs are registered.
- Reset values: o_eng_rst=1; all other outputs 0; state CLEAR; counters 0.
- States:
  - CLEAR: o_eng_rst=1 and o_sni_ready=0 for CLR_CYCLES cycles, counted by clr_cnt. Then go to FEED. On FEED entry, clear the sticky match, length counter, half-word register and trunc flag.
  - FEED: o_eng_rst=0 and o_sni_ready=1. A byte is accepted when valid&&ready.
    - Even position, not last: store the byte in hi_reg. No engine beat.
    - Odd position: drive o_eng_valid=1 and o_eng_data={hi_reg, byte} on the next cycle.
    - Last byte at an even position: drive o_eng_data={byte, PAD_BYTE} on the next cycle.
    - o_eng_valid is high for exactly one cycle per word. Gaps in input create gaps in o_eng_valid; the engine holds its state across gaps.
    - Bytes beyond MAX_LEN are accepted but not forwarded, and they set trunc. If MAX_LEN is odd and the string continues past it, the byte at position MAX_LEN is flushed as {hi, PAD_BYTE}.
    - o_res_len counts every accepted byte.
    - Accepting the last byte moves the FSM to DRAIN, and o_sni_ready drops the next cycle.
  - DRAIN: o_sni_ready=0. Count MATCH_LAT cycles, starting the cycle after the final o_eng_valid. Then go to REPORT.
  - REPORT: o_res_valid=1. o_res_matched, o_res_trunc and o_res_len are held stable until i_res_ready=1. On the handshake cycle, o_res_valid drops the next cycle and the FSM goes to CLEAR.
- Sticky match: OR of i_eng_matched sampled every cycle in FEED and DRAIN, including the final DRAIN cycle. It is never sampled in CLEAR.
- Latency (MATCH_LAT=3, no input gaps): last byte accepted at cycle T → final o_eng_valid at T+1 → DRAIN occupies T+2..T+4 → o_res_valid at T+5.
- Minimum string length is 1 byte; a valid beat always carries a byte.
- i_res_ready held high: the result is consumed in its first valid cycle.
- i_res_ready asserted while o_res_valid=0: ignored.
- i_rst mid-string or mid-result: the string is aborted with no result emitted. The FSM returns to CLEAR with o_eng_rst=1 from the next cycle. Partial words are discarded.
- Width rules: the length counter is 16 bits and saturates. The forward counter compares against MAX_LEN.

Test Plan:
- "ab" then "cd" as two strings, engine model matching on 16'h6364 → two engine beats, 16'h6162 then 16'h6364; results matched=0,len=2 and matched=1,len=2; o_eng_rst high for 4 cycles before each string.
- Odd string "xyz", PAD_BYTE=00 → beats 16'h7879 and 16'h7A00; o_res_len=3; o_res_valid exactly 4 cycles after the second beat.
- 300-byte string, MAX_LEN=255 → 127 full beats plus one padded beat; o_res_trunc=1; o_res_len=300; o_sni_ready high throughout FEED.
- Match pulse arrives on the last DRAIN cycle → o_res_matched=1. Match pulse only during CLEAR → o_res_matched=0.
- i_res_ready held low for 10 cycles → o_res_valid and result fields stable; o_sni_ready=0; no engine beats; handshake → CLEAR next cycle.
- i_rst asserted after 3 bytes of a 6-byte string → no result; o_eng_rst=1 the next cycle; the following string "ab" produces a clean single beat 16'h6162 and a correct result.
